vc_input_buffer: RTL and testbench

VC_INPUT_BUFFER -- requirements
Module: vc_input_buffer

---
 rtl/noc_pkg.sv | 20 ++
 rtl/vc_input_buffer_if.sv | 37 +++
 rtl/vc_fifo.sv | 56 +++++
 rtl/vc_input_buffer.sv | 133 +++++++++++++
 tb/tb_vc_input_buffer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the two-VC router input buffer: default payload width,
// flit layout and the output arbiter state encoding.
package noc_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NUM_VC     = 2;

  typedef struct packed {
    logic                  head;
    logic                  tail;
    logic [DATA_W_DEF-1:0] data;
  } flit_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/vc_input_buffer_if.sv
// Link-side and switch-side signals of the VC input buffer, bundled for port use.
interface vc_input_buffer_if
  import noc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  // Handshakes: a flit moves when its valid is high and the receiver's ready is
  // high in the same cycle. Link side: in_valid with in_ready[in_vc]; the link
  // tracks space via credit_ret. Switch side: vc_valid with vc_ready; while
  // vc_valid && !vc_ready the buffer holds vc_data/vc_head/vc_tail/vc_sel.
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_vc;
  logic              in_head;
  logic              in_tail;
  logic [1:0]        in_ready;
  logic [1:0]        credit_ret;
  logic [DATA_W-1:0] vc_data;
  logic              vc_valid;
  logic              vc_head;
  logic              vc_tail;
  logic              vc_ready;
  logic              vc_sel;
  logic              err;

  modport master (
    output in_data, in_valid, in_vc, in_head, in_tail, vc_ready,
    input  in_ready, credit_ret, vc_data, vc_valid, vc_head, vc_tail, vc_sel, err
  );

  modport slave (
    input  in_data, in_valid, in_vc, in_head, in_tail, vc_ready,
    output in_ready, credit_ret, vc_data, vc_valid, vc_head, vc_tail, vc_sel, err
  );

endinterface

// File: rtl/vc_fifo.sv
// Single-VC flit FIFO: registered storage, wrapping pointers, no write-to-read
// bypass, and a full FIFO refuses a push even when it pops in the same cycle.
module vc_fifo
  import noc_pkg::*;
#(
  parameter int W     = DATA_W_DEF + 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read once count says it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/vc_input_buffer.sv
// Two-VC router input buffer: per-VC FIFOs feeding one switch port through a
// packet-locked round-robin arbiter that discards headless fronts while idle.
module vc_input_buffer
  import noc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic               clk,
  input  logic               reset,
  vc_input_buffer_if.slave   bus,
  output arb_state_t         dbg_state
);

  typedef struct packed {
    logic              head;
    logic              tail;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int EW = $bits(entry_t);

  arb_state_t    state;
  logic          rr_ptr;
  logic          sel_q;
  logic          err_q;
  logic [1:0]    ready;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    empty;
  logic [1:0]    full;
  logic [1:0]    elig;
  logic [1:0]    drop;
  logic [EW-1:0] rdata0;
  logic [EW-1:0] rdata1;
  entry_t        wr_entry;
  entry_t        front [2];
  logic          locked;
  logic          lock_vc;
  logic          out_valid;
  logic          xfer;
  logic          grant_vc;
  logic          rd_vc;

  assign wr_entry = '{head: bus.in_head, tail: bus.in_tail, data: bus.in_data};

  vc_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .reset (reset),
    .push  (push[0]),
    .wdata (wr_entry),
    .pop   (pop[0]),
    .rdata (rdata0),
    .empty (empty[0]),
    .full  (full[0])
  );

  vc_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .reset (reset),
    .push  (push[1]),
    .wdata (wr_entry),
    .pop   (pop[1]),
    .rdata (rdata1),
    .empty (empty[1]),
    .full  (full[1])
  );

  assign front[0] = entry_t'(rdata0);
  assign front[1] = entry_t'(rdata1);

  // No space is advertised while reset is held, so nothing can land mid-reset.
  assign ready   = reset ? 2'b00 : ~full;
  assign push[0] = bus.in_valid && !bus.in_vc && ready[0];
  assign push[1] = bus.in_valid &&  bus.in_vc && ready[1];

  assign locked    = (state != ST_IDLE);
  assign lock_vc   = (state == ST_LOCK1);
  assign out_valid = locked && !empty[lock_vc];
  assign xfer      = out_valid && bus.vc_ready;

  assign elig[0] = !empty[0] && front[0].head;
  assign elig[1] = !empty[1] && front[1].head;

  // Headless fronts are only flushed in an idle cycle where nobody can be granted.
  assign drop = (!locked && (elig == 2'b00))
              ? (~empty & {~front[1].head, ~front[0].head})
              : 2'b00;

  assign pop[0] = drop[0] || (xfer && !lock_vc);
  assign pop[1] = drop[1] || (xfer &&  lock_vc);

  assign grant_vc = (elig == 2'b11) ? rr_ptr : elig[1];
  assign rd_vc    = locked ? lock_vc : sel_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      rr_ptr <= 1'b0;
      sel_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (elig != 2'b00) begin
            state <= grant_vc ? ST_LOCK1 : ST_LOCK0;
            sel_q <= grant_vc;
          end
          if (drop != 2'b00) err_q <= 1'b1;
        end
        ST_LOCK0, ST_LOCK1: begin
          // Only a tail releases the lock; a stray head mid-packet is just data.
          if (xfer && front[lock_vc].tail) begin
            state  <= ST_IDLE;
            rr_ptr <= ~lock_vc;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = ready;
  assign bus.credit_ret = pop;
  assign bus.vc_valid   = out_valid;
  assign bus.vc_data    = front[rd_vc].data;
  assign bus.vc_head    = front[rd_vc].head;
  assign bus.vc_tail    = front[rd_vc].tail;
  assign bus.vc_sel     = sel_q;
  assign bus.err        = err_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Bench for vc_input_buffer: directed packet scenarios plus random traffic, all
// checked cycle by cycle against a queue-based model of the buffering rules.
module tb_vc_input_buffer;
  import noc_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  arb_state_t dut_state;

  vc_input_buffer_if #(.DATA_W(DW)) bus ();

  vc_input_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dut_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  flit_t exp_q0[$];
  flit_t exp_q1[$];
  int    lock_vc;
  bit    rr;
  bit    m_err;
  int    n_cmp;
  int    n_err;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int qsize(int v);
    return (v == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic flit_t qfront(int v);
    return (v == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    lock_vc = -1;
    rr      = 1'b0;
    m_err   = 1'b0;
  endtask

  // One clock cycle: check outputs at negedge, then advance the model at posedge.
  task automatic step();
    bit [1:0] exp_rdy;
    bit [1:0] exp_pop;
    bit       exp_valid;
    bit       el0;
    bit       el1;
    bit       acc;
    bit       drop_cycle;
    bit       tail_out;
    int       grant;
    flit_t    f;
    flit_t    nf;
    @(negedge clk);
    if (reset) model_reset();
    exp_rdy    = 2'b00;
    exp_pop    = 2'b00;
    exp_valid  = 1'b0;
    drop_cycle = 1'b0;
    tail_out   = 1'b0;
    grant      = -1;
    if (!reset) begin
      exp_rdy = {qsize(1) < DEPTH, qsize(0) < DEPTH};
      if (lock_vc < 0) begin
        el0 = (qsize(0) > 0) && qfront(0).head;
        el1 = (qsize(1) > 0) && qfront(1).head;
        if (el0 && el1)  grant = rr ? 1 : 0;
        else if (el0)    grant = 0;
        else if (el1)    grant = 1;
        else begin
          exp_pop[0] = qsize(0) > 0;
          exp_pop[1] = qsize(1) > 0;
          drop_cycle = |exp_pop;
        end
      end else begin
        exp_valid = qsize(lock_vc) > 0;
        if (exp_valid && bus.vc_ready) begin
          exp_pop[lock_vc] = 1'b1;
          tail_out = qfront(lock_vc).tail;
        end
      end
    end
    check("in_ready",   64'(bus.in_ready),   64'(exp_rdy));
    check("vc_valid",   64'(bus.vc_valid),   64'(exp_valid));
    check("credit_ret", 64'(bus.credit_ret), 64'(exp_pop));
    check("err",        64'(bus.err),        64'(m_err));
    if (reset) begin
      check("rst_vc_sel", 64'(bus.vc_sel), 64'(0));
      check("rst_state",  64'(dut_state),  64'(ST_IDLE));
    end
    if (exp_valid) begin
      f = qfront(lock_vc);
      check("vc_data", 64'(bus.vc_data), 64'(f.data));
      check("vc_head", 64'(bus.vc_head), 64'(f.head));
      check("vc_tail", 64'(bus.vc_tail), 64'(f.tail));
      check("vc_sel",  64'(bus.vc_sel),  64'(lock_vc));
    end
    acc = !reset && bus.in_valid && exp_rdy[bus.in_vc];
    nf  = '{head: bus.in_head, tail: bus.in_tail, data: bus.in_data};
    @(posedge clk);
    if (!reset) begin
      if (exp_pop[0]) void'(exp_q0.pop_front());
      if (exp_pop[1]) void'(exp_q1.pop_front());
      if (lock_vc >= 0) begin
        if (tail_out) begin
          rr      = (lock_vc == 0);
          lock_vc = -1;
        end
      end else if (grant >= 0) begin
        lock_vc = grant;
      end
      if (drop_cycle) m_err = 1'b1;
      if (acc) begin
        if (bus.in_vc) exp_q1.push_back(nf);
        else           exp_q0.push_back(nf);
      end
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(bit vc, bit head, bit tail, logic [DW-1:0] data);
    bus.in_valid = 1'b1;
    bus.in_vc    = vc;
    bus.in_head  = head;
    bus.in_tail  = tail;
    bus.in_data  = data;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    bus.in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp        = 0;
    n_err        = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_vc    = 1'b0;
    bus.in_head  = 1'b0;
    bus.in_tail  = 1'b0;
    bus.in_data  = '0;
    bus.vc_ready = 1'b1;
    model_reset();
    #1;
    repeat (2) step();
    reset = 1'b0;
    idle(2);

    // Three-flit packet on VC0 streaming straight through.
    send(1'b0, 1'b1, 1'b0, 32'hA000_0001);
    send(1'b0, 1'b0, 1'b0, 32'hA000_0002);
    send(1'b0, 1'b0, 1'b1, 32'hA000_0003);
    idle(6);

    // Packets queued on both VCs behind a stalled switch: VC0, VC1, VC0, VC1.
    do_reset(1);
    bus.vc_ready = 1'b0;
    send(1'b0, 1'b1, 1'b0, 32'hB000_0001);
    send(1'b0, 1'b0, 1'b1, 32'hB000_0002);
    send(1'b1, 1'b1, 1'b0, 32'hC000_0001);
    send(1'b1, 1'b0, 1'b1, 32'hC000_0002);
    send(1'b0, 1'b1, 1'b1, 32'hB000_0003);
    send(1'b1, 1'b1, 1'b1, 32'hC000_0003);
    idle(2);
    bus.vc_ready = 1'b1;
    idle(12);

    // Fill VC1 while stalled; the fifth flit must be refused.
    do_reset(1);
    bus.vc_ready = 1'b0;
    send(1'b1, 1'b1, 1'b0, 32'hD000_0001);
    send(1'b1, 1'b0, 1'b0, 32'hD000_0002);
    send(1'b1, 1'b1, 1'b0, 32'hD000_0003);
    send(1'b1, 1'b0, 1'b0, 32'hD000_0004);
    send(1'b1, 1'b0, 1'b1, 32'hD000_0005);
    idle(3);
    bus.vc_ready = 1'b1;
    idle(8);
    send(1'b1, 1'b0, 1'b1, 32'hD000_0006);
    idle(3);

    // Headless front flit while idle: dropped with a credit, err sticks.
    do_reset(1);
    send(1'b0, 1'b0, 1'b1, 32'hE000_0001);
    idle(3);
    send(1'b0, 1'b1, 1'b1, 32'hE000_0002);
    idle(5);

    // Reset with two flits of a packet buffered.
    bus.vc_ready = 1'b0;
    send(1'b0, 1'b1, 1'b0, 32'hF000_0001);
    send(1'b0, 1'b0, 1'b0, 32'hF000_0002);
    idle(2);
    do_reset(2);
    idle(3);
    bus.vc_ready = 1'b1;
    idle(2);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 599) == 0);
      bus.vc_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.in_vc    = 1'($urandom_range(0, 1));
      bus.in_head  = ($urandom_range(0, 2) == 0);
      bus.in_tail  = ($urandom_range(0, 2) == 0);
      bus.in_data  = $urandom;
      step();
    end
    reset = 1'b0;
    bus.vc_ready = 1'b1;
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
